armleocpu_mul_unit: RTL

Execute-stage front end for the RV32M multiply instructions (MUL, MULH, MULHSU, MULHU). It sits directly upstream of the 32x32->64 unsigned pipelined multiplier and downstream of the execute stage. It converts signed operands to magnitudes and issues one multiply. It then consumes the 64-bit product, restores the sign, selects the requested 32-bit half and returns it to execute with a one-cycle ready pulse.

---
 rtl/armleocpu_mul_unit_pkg.sv | 25 ++
 rtl/armleocpu_mul_unit.sv | 101 ++++++++++
 2 files changed

// File: rtl/armleocpu_mul_unit_pkg.sv
// Shared definitions for the RV32M multiply front end:
// funct3 codes, FSM states and a magnitude helper.
package armleocpu_mul_unit_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE,
    S_FLUSH
  } mul_state_t;

  function automatic logic [31:0] mag32(
    input logic [31:0] v,
    input logic        s
  );
    return s ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/armleocpu_mul_unit.sv
// RV32M multiply front end: sign handling around an external
// unsigned 32x32->64 pipelined multiplier.
module armleocpu_mul_unit
  import armleocpu_mul_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        c_valid,
  input  logic        c_kill,
  input  logic [2:0]  c_funct3,
  input  logic [31:0] c_rs1,
  input  logic [31:0] c_rs2,
  output logic        c_ready,
  output logic        c_error,
  output logic [31:0] c_result,
  output logic        m_valid,
  output logic [31:0] m_factor0,
  output logic [31:0] m_factor1,
  input  logic        m_ready,
  input  logic [63:0] m_result
);

  mul_state_t state;
  logic       is_mul_q;
  logic       neg_q;
  logic       sa;
  logic       sb;
  logic       is_mul;
  logic [63:0] prod;

  always_comb begin
    sa     = 1'b0;
    sb     = 1'b0;
    is_mul = 1'b0;
    unique case (1'b1)
      c_funct3 == F3_MUL:    is_mul = 1'b1;
      c_funct3 == F3_MULH: begin
        sa = c_rs1[31];
        sb = c_rs2[31];
      end
      c_funct3 == F3_MULHSU: sa = c_rs1[31];
      default: ;
    endcase
  end

  // 64-bit wrap on negate; the magnitudes of INT_MIN stay exact.
  assign prod = neg_q ? (~m_result + 64'd1) : m_result;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      is_mul_q  <= 1'b0;
      neg_q     <= 1'b0;
      c_ready   <= 1'b0;
      c_error   <= 1'b0;
      c_result  <= 32'd0;
      m_valid   <= 1'b0;
      m_factor0 <= 32'd0;
      m_factor1 <= 32'd0;
    end else begin
      c_ready <= 1'b0;
      m_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (c_valid && !c_kill) begin
            if (c_funct3[2]) begin
              c_ready  <= 1'b1;
              c_error  <= 1'b1;
              c_result <= 32'd0;
              state    <= S_DONE;
            end else begin
              is_mul_q  <= is_mul;
              neg_q     <= sa ^ sb;
              m_factor0 <= mag32(c_rs1, sa);
              m_factor1 <= mag32(c_rs2, sb);
              m_valid   <= 1'b1;
              state     <= S_ISSUE;
            end
          end
        end
        S_ISSUE: state <= c_kill ? S_FLUSH : S_WAIT;
        S_WAIT: begin
          if (c_kill) begin
            state <= m_ready ? S_IDLE : S_FLUSH;
          end else if (m_ready) begin
            c_ready  <= 1'b1;
            c_error  <= 1'b0;
            c_result <= is_mul_q ? prod[31:0] : prod[63:32];
            state    <= S_DONE;
          end
        end
        S_DONE: state <= S_IDLE;
        S_FLUSH: begin
          if (m_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
